// File: rtl/mips_pkg.sv
// Shared control-field indices and MEM-stage FSM state type.
package mips_pkg;
    localparam int M_BRANCH    = 2;
    localparam int M_READ      = 1;
    localparam int M_WRITE     = 0;
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    typedef enum logic {IDLE, WAIT} mem_state_t;
endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears the WB control only; the data
// fields keep their previous contents because wb = 0 makes them irrelevant.
module mem_wb_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        bubble,
    input  logic [1:0]  wb,
    input  logic [4:0]  rd,
    input  logic [31:0] alu_res,
    input  logic        rdata_en,
    input  logic [31:0] rdata,
    output logic [1:0]  wb_WB,
    output logic [4:0]  rd_WB,
    output logic [31:0] read_data_wb,
    output logic [31:0] alu_res_wb
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_WB        <= 2'b00;
            rd_WB        <= 5'd0;
            read_data_wb <= 32'd0;
            alu_res_wb   <= 32'd0;
        end else if (bubble) begin
            wb_WB <= 2'b00;
        end else begin
            wb_WB      <= wb;
            rd_WB      <= rd;
            alu_res_wb <= alu_res;
            if (rdata_en)
                read_data_wb <= rdata;
        end
    end
endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: handshaked data-memory access, stall, branch decision.
// Optional access timeout is enabled with the MEM_TIMEOUT_EN macro.
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] res,
    input  logic [31:0] write_data_ex,
    input  logic [4:0]  write_register_ex,
    input  logic        zero,
    input  logic [2:0]  m_MEM,
    input  logic [1:0]  wb_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall_mem,
    output logic        pcsrc,
    output logic [1:0]  wb_WB,
    output logic [4:0]  rd_WB,
    output logic [31:0] read_data_wb,
    output logic [31:0] alu_res_wb,
    output logic [31:0] write_data_reg,
    output logic        misalign_err,
    output logic        bus_err
);
    import mips_pkg::*;

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("mem_stage: TIMEOUT must be >= 2");
    end

    mem_state_t  state, state_next;
    logic [31:0] h_addr, h_wdata;
    logic        h_we;
    logic [4:0]  h_rd;
    logic [1:0]  h_wb;

    logic        access, aligned;
    logic        req, stall, hold_load, bubble, rdata_en, misalign_next;
    logic [1:0]  wb_in;
    logic [4:0]  rd_in;
    logic [31:0] alu_in;

    assign access  = m_MEM[M_READ] | m_MEM[M_WRITE];
    assign aligned = (res[1:0] == 2'b00);

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          cnt_clr, cnt_inc, bus_next;
`endif

    always_comb begin
        state_next    = state;
        req           = 1'b0;
        dmem_we       = 1'b0;
        dmem_addr     = res;
        dmem_wdata    = write_data_ex;
        stall         = 1'b0;
        hold_load     = 1'b0;
        bubble        = 1'b0;
        wb_in         = wb_MEM;
        rd_in         = write_register_ex;
        alu_in        = res;
        rdata_en      = 1'b0;
        misalign_next = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        bus_next = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (access) begin
                    if (!aligned) begin
                        bubble        = 1'b1;
                        misalign_next = 1'b1;
                    end else begin
                        req     = 1'b1;
                        // read+write together is illegal and behaves as a store
                        dmem_we = m_MEM[M_WRITE];
                        if (dmem_ready) begin
                            rdata_en = ~m_MEM[M_WRITE];
                        end else begin
                            stall      = 1'b1;
                            hold_load  = 1'b1;
                            bubble     = 1'b1;
                            state_next = WAIT;
`ifdef MEM_TIMEOUT_EN
                            cnt_clr = 1'b1;
`endif
                        end
                    end
                end
            end
            WAIT: begin
                req        = 1'b1;
                dmem_we    = h_we;
                dmem_addr  = h_addr;
                dmem_wdata = h_wdata;
                wb_in      = h_wb;
                rd_in      = h_rd;
                alu_in     = h_addr;
                if (dmem_ready) begin
                    rdata_en   = ~h_we;
                    state_next = IDLE;
                end else begin
                    bubble = 1'b1;
`ifdef MEM_TIMEOUT_EN
                    if (cnt == CW'(TIMEOUT - 1)) begin
                        state_next = IDLE;
                        bus_next   = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        cnt_inc = 1'b1;
                    end
`else
                    stall = 1'b1;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Reset must drop a request immediately, even mid-WAIT.
    assign dmem_req  = req & ~rst;
    assign stall_mem = stall & ~rst;
    assign pcsrc     = (state == IDLE) & m_MEM[M_BRANCH] & zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            misalign_err <= 1'b0;
            h_addr       <= 32'd0;
            h_wdata      <= 32'd0;
            h_we         <= 1'b0;
            h_rd         <= 5'd0;
            h_wb         <= 2'b00;
        end else begin
            state        <= state_next;
            misalign_err <= misalign_next;
            if (hold_load) begin
                h_addr  <= res;
                h_wdata <= write_data_ex;
                h_we    <= m_MEM[M_WRITE];
                h_rd    <= write_register_ex;
                h_wb    <= wb_MEM;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            bus_err <= 1'b0;
        end else begin
            bus_err <= bus_next;
            if (cnt_clr)
                cnt <= '0;
            else if (cnt_inc)
                cnt <= cnt + 1'b1;
        end
    end
`else
    assign bus_err = 1'b0;
`endif

    mem_wb_reg u_mem_wb_reg (
        .clk          (clk),
        .rst          (rst),
        .bubble       (bubble),
        .wb           (wb_in),
        .rd           (rd_in),
        .alu_res      (alu_in),
        .rdata_en     (rdata_en),
        .rdata        (dmem_rdata),
        .wb_WB        (wb_WB),
        .rd_WB        (rd_WB),
        .read_data_wb (read_data_wb),
        .alu_res_wb   (alu_res_wb)
    );

    assign write_data_reg = wb_WB[WB_MEMTOREG] ? read_data_wb : alu_res_wb;
endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (timeout scenario needs MEM_TIMEOUT_EN).
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] res, write_data_ex, dmem_addr, dmem_wdata, dmem_rdata;
    logic [31:0] read_data_wb, alu_res_wb, write_data_reg;
    logic [4:0]  write_register_ex, rd_WB;
    logic [2:0]  m_MEM;
    logic [1:0]  wb_MEM, wb_WB;
    logic        zero, dmem_req, dmem_we, dmem_ready, stall_mem, pcsrc;
    logic        misalign_err, bus_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .res(res), .write_data_ex(write_data_ex),
        .write_register_ex(write_register_ex), .zero(zero), .m_MEM(m_MEM),
        .wb_MEM(wb_MEM), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .stall_mem(stall_mem), .pcsrc(pcsrc),
        .wb_WB(wb_WB), .rd_WB(rd_WB), .read_data_wb(read_data_wb),
        .alu_res_wb(alu_res_wb), .write_data_reg(write_data_reg),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    task automatic idle_inputs();
        m_MEM = 3'b000; wb_MEM = 2'b00; res = 32'd0; write_data_ex = 32'd0;
        write_register_ex = 5'd0; zero = 1'b0; dmem_ready = 1'b0; dmem_rdata = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_MEM = 3'b010; wb_MEM = 2'b11; res = 32'h100; write_data_ex = 32'h5;
        write_register_ex = 5'd4; zero = 1'b0; dmem_ready = 1'b1; dmem_rdata = 32'h77;
        #2;
        n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", dmem_req); end
        n_cmp++; if (wb_WB !== 2'b00 || rd_WB !== 5'd0) begin n_err++; $display("FAIL reset_wb_rd: got %b/%0d want 00/0", wb_WB, rd_WB); end
        n_cmp++; if (read_data_wb !== 32'd0 || alu_res_wb !== 32'd0) begin n_err++; $display("FAIL reset_data: got %h/%h want 0/0", read_data_wb, alu_res_wb); end
        n_cmp++; if (misalign_err !== 1'b0 || bus_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b/%b want 0/0", misalign_err, bus_err); end
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_passthrough();
        @(negedge clk);
        wb_MEM = 2'b10; res = 32'h0000_0042; write_register_ex = 5'd5;
        #1;
        n_cmp++; if (dmem_req !== 1'b0 || stall_mem !== 1'b0) begin n_err++; $display("FAIL pass_req_stall: got %b/%b want 0/0", dmem_req, stall_mem); end
        @(posedge clk); #1;
        n_cmp++; if (wb_WB !== 2'b10 || rd_WB !== 5'd5) begin n_err++; $display("FAIL pass_wb_rd: got %b/%0d want 10/5", wb_WB, rd_WB); end
        n_cmp++; if (write_data_reg !== 32'h42) begin n_err++; $display("FAIL pass_wdr: got %h want 00000042", write_data_reg); end
    endtask

    task automatic test_load_fast();
        @(negedge clk);
        m_MEM = 3'b010; wb_MEM = 2'b11; res = 32'h100; write_register_ex = 5'd7;
        dmem_ready = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h100) begin n_err++; $display("FAIL lfast_port: got req=%b we=%b addr=%h want 1/0/100", dmem_req, dmem_we, dmem_addr); end
        n_cmp++; if (stall_mem !== 1'b0) begin n_err++; $display("FAIL lfast_stall: got %b want 0", stall_mem); end
        @(posedge clk); #1;
        n_cmp++; if (read_data_wb !== 32'hDEAD_BEEF || write_data_reg !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL lfast_data: got %h/%h want deadbeef", read_data_wb, write_data_reg); end
        n_cmp++; if (wb_WB !== 2'b11 || rd_WB !== 5'd7) begin n_err++; $display("FAIL lfast_wb_rd: got %b/%0d want 11/7", wb_WB, rd_WB); end
    endtask

    task automatic test_store_wait();
        @(negedge clk);
        idle_inputs();
        m_MEM = 3'b001; wb_MEM = 2'b00; res = 32'h204; write_data_ex = 32'h1234; write_register_ex = 5'd2;
        for (int c = 1; c <= 4; c++) begin
            #1;
            n_cmp++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h204 || dmem_wdata !== 32'h1234) begin
                n_err++; $display("FAIL store_port c%0d: got req=%b we=%b addr=%h wdata=%h want 1/1/204/1234", c, dmem_req, dmem_we, dmem_addr, dmem_wdata); end
            n_cmp++; if (stall_mem !== (c < 4)) begin n_err++; $display("FAIL store_stall c%0d: got %b want %b", c, stall_mem, (c < 4)); end
            if (c == 2) begin
                n_cmp++; if (pcsrc !== 1'b0) begin n_err++; $display("FAIL store_pcsrc_wait: got %b want 0", pcsrc); end
            end
            @(posedge clk); #1;
            if (c < 4) begin
                n_cmp++; if (wb_WB !== 2'b00) begin n_err++; $display("FAIL store_bubble c%0d: got %b want 00", c, wb_WB); end
            end
            @(negedge clk);
            // disturb EX-side inputs: held values must drive the port
            m_MEM = 3'b100; zero = 1'b1; res = 32'hFFF0; write_data_ex = 32'h0; write_register_ex = 5'd31;
            dmem_ready = (c == 3);
        end
        n_cmp++; if (alu_res_wb !== 32'h204 || rd_WB !== 5'd2 || wb_WB !== 2'b00) begin
            n_err++; $display("FAIL store_done: got alu=%h rd=%0d wb=%b want 204/2/00", alu_res_wb, rd_WB, wb_WB); end
        idle_inputs();
    endtask

    task automatic test_load_wait();
        @(negedge clk);
        m_MEM = 3'b010; wb_MEM = 2'b11; res = 32'h300; write_register_ex = 5'd9;
        @(posedge clk); #1;
        n_cmp++; if (wb_WB !== 2'b00) begin n_err++; $display("FAIL lwait_bubble: got %b want 00", wb_WB); end
        @(negedge clk);
        idle_inputs();
        dmem_ready = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        #1;
        n_cmp++; if (stall_mem !== 1'b0 || dmem_addr !== 32'h300 || dmem_req !== 1'b1) begin
            n_err++; $display("FAIL lwait_ready: got stall=%b addr=%h req=%b want 0/300/1", stall_mem, dmem_addr, dmem_req); end
        @(posedge clk); #1;
        n_cmp++; if (write_data_reg !== 32'hCAFE_F00D || rd_WB !== 5'd9 || wb_WB !== 2'b11) begin
            n_err++; $display("FAIL lwait_done: got %h/%0d/%b want cafef00d/9/11", write_data_reg, rd_WB, wb_WB); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        m_MEM = 3'b010; wb_MEM = 2'b11; res = 32'h102; write_register_ex = 5'd3; dmem_ready = 1'b1;
        #1;
        n_cmp++; if (dmem_req !== 1'b0 || stall_mem !== 1'b0) begin n_err++; $display("FAIL mis_req: got %b/%b want 0/0", dmem_req, stall_mem); end
        @(posedge clk); #1;
        n_cmp++; if (misalign_err !== 1'b1 || wb_WB !== 2'b00) begin n_err++; $display("FAIL mis_pulse: got err=%b wb=%b want 1/00", misalign_err, wb_WB); end
        @(negedge clk);
        idle_inputs();
        @(posedge clk); #1;
        n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL mis_clear: got %b want 0", misalign_err); end
    endtask

    task automatic test_branch();
        @(negedge clk);
        m_MEM = 3'b100; zero = 1'b1;
        #1;
        n_cmp++; if (pcsrc !== 1'b1) begin n_err++; $display("FAIL br_taken: got %b want 1", pcsrc); end
        zero = 1'b0;
        #1;
        n_cmp++; if (pcsrc !== 1'b0) begin n_err++; $display("FAIL br_not_taken: got %b want 0", pcsrc); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        m_MEM = 3'b010; wb_MEM = 2'b10; res = 32'h500; write_register_ex = 5'd12;
        @(posedge clk); #1;
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL rstw_pre: got %b want 1", dmem_req); end
        rst = 1'b1;
        #1;
        n_cmp++; if (dmem_req !== 1'b0 || stall_mem !== 1'b0) begin n_err++; $display("FAIL rstw_req: got %b/%b want 0/0", dmem_req, stall_mem); end
        n_cmp++; if (wb_WB !== 2'b00 || rd_WB !== 5'd0 || read_data_wb !== 32'd0 || alu_res_wb !== 32'd0) begin
            n_err++; $display("FAIL rstw_wb: got %b/%0d/%h/%h want zeros", wb_WB, rd_WB, read_data_wb, alu_res_wb); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL rstw_after: got %b want 0", dmem_req); end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        m_MEM = 3'b010; wb_MEM = 2'b11; res = 32'h400; write_register_ex = 5'd6;
        @(posedge clk); #1;
`ifdef MEM_TIMEOUT_EN
        for (int w = 1; w <= 4; w++) begin
            @(negedge clk);
            idle_inputs();
            #1;
            n_cmp++; if (stall_mem !== (w < 4)) begin n_err++; $display("FAIL to_stall w%0d: got %b want %b", w, stall_mem, (w < 4)); end
            @(posedge clk); #1;
        end
        n_cmp++; if (bus_err !== 1'b1 || wb_WB !== 2'b00) begin n_err++; $display("FAIL to_pulse: got err=%b wb=%b want 1/00", bus_err, wb_WB); end
        @(negedge clk); #1;
        n_cmp++; if (dmem_req !== 1'b0 || stall_mem !== 1'b0) begin n_err++; $display("FAIL to_idle: got %b/%b want 0/0", dmem_req, stall_mem); end
        @(posedge clk); #1;
        n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL to_clear: got %b want 0", bus_err); end
`else
        for (int w = 1; w <= 6; w++) begin
            @(negedge clk);
            idle_inputs();
            #1;
            n_cmp++; if (stall_mem !== 1'b1 || dmem_req !== 1'b1 || bus_err !== 1'b0) begin
                n_err++; $display("FAIL nto_wait w%0d: got stall=%b req=%b err=%b want 1/1/0", w, stall_mem, dmem_req, bus_err); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        dmem_ready = 1'b1; dmem_rdata = 32'h0BAD_CAFE;
        @(posedge clk); #1;
        n_cmp++; if (read_data_wb !== 32'h0BAD_CAFE || rd_WB !== 5'd6) begin n_err++; $display("FAIL nto_done: got %h/%0d want 0badcafe/6", read_data_wb, rd_WB); end
        @(negedge clk);
        idle_inputs();
`endif
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load_fast();
        test_store_wait();
        test_load_wait();
        test_misaligned();
        test_branch();
        test_reset_in_wait();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
